// File: rtl/mem_stage.sv
// ============================================================================
//  Module   : mem_stage
//  Brief    : RISC-V MEM stage: request/ack data-memory port, stall, MEM/WB
//             register, branch resolution.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic        MemRead,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic [31:0] adderout2,
    input  logic [31:0] ALUresult,
    input  logic        zero,
    input  logic [31:0] Regdata2,
    input  logic [4:0]  writeReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        MemtoReg_O,
    output logic        RegWrite_O,
    output logic [31:0] memdata_O,
    output logic [31:0] ALUresult_O,
    output logic [4:0]  writeReg_O,
    output logic        valid_O,
    output logic        misalign_O,
    output logic        timeout_O,
    output logic        err_O
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] C_LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic        memtoreg_q, memtoreg_d;
    logic        regwrite_q, regwrite_d;
    logic [31:0] memdata_q, memdata_d;
    logic [31:0] aluresult_q, aluresult_d;
    logic [4:0]  writereg_q, writereg_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic        err_q, err_d;

    logic w_memop;
    logic w_aligned;
    logic w_timeout_now;

    assign w_memop       = MemRead | MemWrite;
    assign w_aligned     = (ALUresult[1:0] == 2'b00);
    assign w_timeout_now = (state_q == ACCESS) && !dmem_ack && (wait_q == C_LAST_WAIT);

    assign stall = ((state_q == IDLE) && w_memop && w_aligned)
                 | ((state_q == ACCESS) && !dmem_ack && !w_timeout_now);

    assign pcsrc         = branch & zero;
    assign branch_target = adderout2;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        // MEM/WB defaults to a bubble; only completing instructions overwrite it
        memtoreg_d   = 1'b0;
        regwrite_d   = 1'b0;
        memdata_d    = 32'h0;
        aluresult_d  = 32'h0;
        writereg_d   = 5'h0;
        valid_d      = 1'b0;
        misalign_d   = 1'b0;
        timeout_d    = 1'b0;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (w_memop && w_aligned) begin
                    state_d      = ACCESS;
                    wait_d       = 8'h0;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = MemWrite;
                    dmem_addr_d  = {ALUresult[31:2], 2'b00};
                    dmem_wdata_d = Regdata2;
                end else if (w_memop) begin
                    misalign_d = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    memtoreg_d  = MemtoReg;
                    regwrite_d  = RegWrite;
                    aluresult_d = ALUresult;
                    writereg_d  = writeReg;
                    valid_d     = 1'b1;
                end
            end
            ACCESS: begin
                // ack takes priority over a timeout landing on the same cycle
                if (dmem_ack) begin
                    state_d     = IDLE;
                    dmem_req_d  = 1'b0;
                    memtoreg_d  = MemtoReg;
                    regwrite_d  = RegWrite;
                    aluresult_d = ALUresult;
                    writereg_d  = writeReg;
                    memdata_d   = dmem_we_q ? 32'h0 : dmem_rdata;
                    valid_d     = 1'b1;
                end else if (w_timeout_now) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                    timeout_d  = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_q       <= 8'h0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_wdata_q <= 32'h0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            memdata_q    <= 32'h0;
            aluresult_q  <= 32'h0;
            writereg_q   <= 5'h0;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            memdata_q    <= memdata_d;
            aluresult_q  <= aluresult_d;
            writereg_q   <= writereg_d;
            valid_q      <= valid_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
        end
    end

    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign MemtoReg_O  = memtoreg_q;
    assign RegWrite_O  = regwrite_q;
    assign memdata_O   = memdata_q;
    assign ALUresult_O = aluresult_q;
    assign writeReg_O  = writereg_q;
    assign valid_O     = valid_q;
    assign misalign_O  = misalign_q;
    assign timeout_O   = timeout_q;
    assign err_O       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Self-checking bench for mem_stage (vector table + handshake runs).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch, MemRead, MemtoReg, MemWrite, RegWrite, zero;
    logic [31:0] adderout2, ALUresult, Regdata2, dmem_rdata;
    logic [4:0]  writeReg;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, pcsrc;
    logic [31:0] dmem_addr, dmem_wdata, branch_target, memdata_O, ALUresult_O;
    logic        MemtoReg_O, RegWrite_O, valid_O, misalign_O, timeout_O, err_O;
    logic [4:0]  writeReg_O;

    int total = 0;
    int bad   = 0;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .branch(branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .RegWrite(RegWrite),
        .adderout2(adderout2), .ALUresult(ALUresult), .zero(zero),
        .Regdata2(Regdata2), .writeReg(writeReg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
        .MemtoReg_O(MemtoReg_O), .RegWrite_O(RegWrite_O), .memdata_O(memdata_O),
        .ALUresult_O(ALUresult_O), .writeReg_O(writeReg_O), .valid_O(valid_O),
        .misalign_O(misalign_O), .timeout_O(timeout_O), .err_O(err_O)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br, zr, mr, mw, m2r, rw;
        logic [31:0] alu, tgt;
        logic [4:0]  wr;
        logic        e_pcsrc, e_stall, e_rw, e_m2r, e_valid, e_mis, e_err;
        logic [31:0] e_alu;
        logic [4:0]  e_wr;
    } vec_t;

    function automatic vec_t mkv(
        input logic br, zr, mr, mw, m2r, rw,
        input logic [31:0] alu, tgt, input logic [4:0] wr,
        input logic e_pcsrc, e_rw, e_m2r, e_valid, e_mis, e_err,
        input logic [31:0] e_alu, input logic [4:0] e_wr);
        vec_t v;
        v.br = br; v.zr = zr; v.mr = mr; v.mw = mw; v.m2r = m2r; v.rw = rw;
        v.alu = alu; v.tgt = tgt; v.wr = wr;
        v.e_pcsrc = e_pcsrc; v.e_stall = 1'b0; v.e_rw = e_rw; v.e_m2r = e_m2r;
        v.e_valid = e_valid; v.e_mis = e_mis; v.e_err = e_err;
        v.e_alu = e_alu; v.e_wr = e_wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_nop();
        branch = 0; MemRead = 0; MemtoReg = 0; MemWrite = 0; RegWrite = 0; zero = 0;
        adderout2 = 0; ALUresult = 0; Regdata2 = 0; writeReg = 0;
    endtask

    task automatic do_nop();
        @(negedge clk);
        set_nop();
        dmem_ack = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; set_nop(); dmem_ack = 0;
        @(posedge clk); #1;
        chk("rst_req", {31'b0, dmem_req}, 0);
        chk("rst_valid", {31'b0, valid_O}, 0);
        chk("rst_err", {31'b0, err_O}, 0);
        chk("rst_alu", ALUresult_O, 0);
        @(negedge clk);
        reset = 0;
    endtask

    // Runs one aligned memory op; ack_at = ACCESS cycle index of ack (0 = never).
    task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wr, input int ack_at, input logic [31:0] rd,
                          output int nstall);
        logic s;
        bit   done;
        nstall = 0;
        done   = 0;
        @(negedge clk);
        branch = 0; zero = 0; MemRead = !we; MemWrite = we; MemtoReg = !we; RegWrite = !we;
        ALUresult = addr; Regdata2 = wd; writeReg = wr;
        for (int c = 0; c < 20 && !done; c++) begin
            dmem_ack   = (c != 0) && (c == ack_at);
            dmem_rdata = dmem_ack ? rd : 32'h0BAD_0BAD;
            #1 s = stall;
            if (s) nstall++;
            @(posedge clk); #1;
            if (!s) begin
                done = 1;
            end else begin
                chk("req_held", {31'b0, dmem_req}, 1);
                chk("addr_held", dmem_addr, addr);
                chk("we_held", {31'b0, dmem_we}, {31'b0, we});
                chk("wdata_held", dmem_wdata, wd);
                chk("stall_bubble", {31'b0, valid_O}, 0);
                @(negedge clk);
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL mem_op_bound: stall never released");
        end
    endtask

    vec_t vecs[8];
    int   ns;

    initial begin
        reset = 1; set_nop(); dmem_ack = 0; dmem_rdata = 0;
        // ALU pass-through, branches and misaligned accesses
        vecs[0] = mkv(0,0,0,0,0,1, 32'h1234, 32'h0, 5'd7,      0,1,0,1,0,0, 32'h1234, 5'd7);
        vecs[1] = mkv(1,1,0,0,0,0, 32'h0, 32'h400, 5'd0,       1,0,0,1,0,0, 32'h0, 5'd0);
        vecs[2] = mkv(1,0,0,0,0,0, 32'h8, 32'h800, 5'd0,       0,0,0,1,0,0, 32'h8, 5'd0);
        vecs[3] = mkv(0,0,0,0,1,1, 32'hFFFF_FFFF, 32'h0, 5'd31, 0,1,1,1,0,0, 32'hFFFF_FFFF, 5'd31);
        vecs[4] = mkv(0,0,1,0,1,1, 32'h102, 32'h0, 5'd3,       0,0,0,0,1,1, 32'h0, 5'd0);
        vecs[5] = mkv(0,0,0,0,0,1, 32'h44, 32'h0, 5'd9,        0,1,0,1,0,1, 32'h44, 5'd9);
        vecs[6] = mkv(0,0,0,1,0,0, 32'h21, 32'h0, 5'd0,        0,0,0,0,1,1, 32'h0, 5'd0);
        vecs[7] = mkv(0,0,0,0,0,0, 32'h0, 32'h0, 5'd0,         0,0,0,1,0,1, 32'h0, 5'd0);

        do_reset();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            branch = vecs[i].br; zero = vecs[i].zr; MemRead = vecs[i].mr; MemWrite = vecs[i].mw;
            MemtoReg = vecs[i].m2r; RegWrite = vecs[i].rw; ALUresult = vecs[i].alu;
            adderout2 = vecs[i].tgt; writeReg = vecs[i].wr; Regdata2 = 32'h5555_AAAA;
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_pcsrc", i), {31'b0, pcsrc}, {31'b0, vecs[i].e_pcsrc});
            chk($sformatf("v%0d_target", i), branch_target, vecs[i].tgt);
            @(posedge clk); #1;
            chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, 0);
            chk($sformatf("v%0d_rw", i), {31'b0, RegWrite_O}, {31'b0, vecs[i].e_rw});
            chk($sformatf("v%0d_m2r", i), {31'b0, MemtoReg_O}, {31'b0, vecs[i].e_m2r});
            chk($sformatf("v%0d_valid", i), {31'b0, valid_O}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_mis", i), {31'b0, misalign_O}, {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d_err", i), {31'b0, err_O}, {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d_alu", i), ALUresult_O, vecs[i].e_alu);
            chk($sformatf("v%0d_wr", i), {27'b0, writeReg_O}, {27'b0, vecs[i].e_wr});
            chk($sformatf("v%0d_mdata", i), memdata_O, 0);
        end

        do_reset();

        // Load at 0x100, ack on 4th ACCESS cycle (also races the MAX_WAIT=4 limit)
        mem_op(1'b0, 32'h100, 32'h0, 5'd5, 4, 32'hDEAD_BEEF, ns);
        chk("ld_stalls", ns, 4);
        chk("ld_mdata", memdata_O, 32'hDEAD_BEEF);
        chk("ld_m2r", {31'b0, MemtoReg_O}, 1);
        chk("ld_rw", {31'b0, RegWrite_O}, 1);
        chk("ld_valid", {31'b0, valid_O}, 1);
        chk("ld_alu", ALUresult_O, 32'h100);
        chk("ld_wr", {27'b0, writeReg_O}, 5);
        chk("ld_req", {31'b0, dmem_req}, 0);
        chk("ld_timeout", {31'b0, timeout_O}, 0);
        chk("ld_err", {31'b0, err_O}, 0);

        // Store 0xCAFE to 0x20, zero-wait ack; back-to-back with the load
        mem_op(1'b1, 32'h20, 32'hCAFE, 5'd0, 1, 32'h0, ns);
        chk("st_stalls", ns, 1);
        chk("st_mdata", memdata_O, 0);
        chk("st_valid", {31'b0, valid_O}, 1);
        chk("st_rw", {31'b0, RegWrite_O}, 0);
        chk("st_req", {31'b0, dmem_req}, 0);
        chk("st_err", {31'b0, err_O}, 0);

        // Timeout: no ack at all
        mem_op(1'b0, 32'h40, 32'h0, 5'd6, 0, 32'h0, ns);
        chk("to_stalls", ns, 4);
        chk("to_pulse", {31'b0, timeout_O}, 1);
        chk("to_err", {31'b0, err_O}, 1);
        chk("to_valid", {31'b0, valid_O}, 0);
        chk("to_rw", {31'b0, RegWrite_O}, 0);
        chk("to_mdata", memdata_O, 0);
        chk("to_req", {31'b0, dmem_req}, 0);
        do_nop();
        chk("to_pulse_end", {31'b0, timeout_O}, 0);
        chk("to_err_sticky", {31'b0, err_O}, 1);
        chk("to_nop_valid", {31'b0, valid_O}, 1);

        // Reset in the middle of an access, then a stray ack in IDLE
        @(negedge clk);
        MemRead = 1; MemtoReg = 1; RegWrite = 1; ALUresult = 32'h200; writeReg = 5'd4;
        dmem_ack = 0;
        @(posedge clk); #1;
        chk("mid_req_up", {31'b0, dmem_req}, 1);
        @(negedge clk);
        reset = 1; set_nop();
        @(posedge clk); #1;
        chk("mid_rst_req", {31'b0, dmem_req}, 0);
        chk("mid_rst_addr", dmem_addr, 0);
        chk("mid_rst_err", {31'b0, err_O}, 0);
        chk("mid_rst_valid", {31'b0, valid_O}, 0);
        @(negedge clk);
        reset = 0; dmem_ack = 1; dmem_rdata = 32'h5555_5555;
        #1;
        chk("idle_ack_stall", {31'b0, stall}, 0);
        @(posedge clk); #1;
        chk("idle_ack_req", {31'b0, dmem_req}, 0);
        chk("idle_ack_mdata", memdata_O, 0);
        chk("idle_ack_valid", {31'b0, valid_O}, 1);
        chk("idle_ack_err", {31'b0, err_O}, 0);
        do_nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
